// File: rtl/date_pkg.sv
// rtl/date_pkg.sv - shared field codes, state enum, month-length table and BCD helpers for the date path
package date_pkg;

    localparam logic [3:0] DIR_NONE  = 4'd0;
    localparam logic [3:0] DIR_DAY   = 4'd3;
    localparam logic [3:0] DIR_MONTH = 4'd4;
    localparam logic [3:0] DIR_YEAR  = 4'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // 10*hi+lo is a multiple of 4 iff (2*hi+lo) is: odd tens need lo in {2,6}, even tens lo in {0,4,8}
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4]) begin
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        end
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    function automatic logic [7:0] month_days(input logic [7:0] month, input logic leap);
        case (month)
            8'h02:                      return leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

endpackage

// File: rtl/bcd_field_step.sv
// rtl/bcd_field_step.sv - combinational packed-BCD up/down step with wrap between min and max
module bcd_field_step
    import date_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] min_val,
    input  logic [7:0] max_val,
    input  logic       up,
    input  logic       down,
    output logic [7:0] next_val
);

    // Packed BCD orders the same as its decimal value, so plain compares are safe
    always_comb begin
        next_val = value;
        if (up && !down) begin
            next_val = (value >= max_val) ? min_val : bcd_inc(value);
        end else if (down && !up) begin
            next_val = (value <= min_val) ? max_val : bcd_dec(value);
        end
    end

endmodule

// File: rtl/date_edit_ctrl.sv
// rtl/date_edit_ctrl.sv - date register owner: RTC tracking, button editing, req/ack commit (leap: DATE_EDIT_LEAP_EN)
module date_edit_ctrl #(
    parameter logic [3:0]  DIR_DAY     = date_pkg::DIR_DAY,
    parameter logic [3:0]  DIR_MONTH   = date_pkg::DIR_MONTH,
    parameter logic [3:0]  DIR_YEAR    = date_pkg::DIR_YEAR,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       programar_on,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       rtc_valid,
    input  logic [7:0] rtc_day,
    input  logic [7:0] rtc_month,
    input  logic [7:0] rtc_year,
    input  logic       write_ack,
    output logic [7:0] fecha_out1,
    output logic [7:0] fecha_out2,
    output logic [7:0] fecha_out3,
    output logic [3:0] direccion_actual_pantalla,
    output logic       write_req,
    output logic       write_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

    date_pkg::state_t state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] day_next, month_next, year_next;
    logic [3:0] dir_next;
    logic       req_next, err_next;

    logic       edit_active, step_up, step_down, move_right, move_left;
    logic       on_day, on_month, on_year;
    logic       leap_cur, leap_new;
    logic [7:0] day_max_cur, day_max_new;
    logic [7:0] day_step, month_step, year_step, day_fixed;
    logic [3:0] cursor_moved;

    assign edit_active = (state == date_pkg::EDIT) && programar_on;
    assign step_up     = edit_active && btn_up && !btn_down;
    assign step_down   = edit_active && btn_down && !btn_up;
    assign move_right  = edit_active && btn_right && !btn_left;
    assign move_left   = edit_active && btn_left && !btn_right;

    assign on_day   = (direccion_actual_pantalla == DIR_DAY);
    assign on_month = (direccion_actual_pantalla == DIR_MONTH);
    assign on_year  = (direccion_actual_pantalla == DIR_YEAR);

`ifdef DATE_EDIT_LEAP_EN
    assign leap_cur = date_pkg::bcd_div4(fecha_out3);
    assign leap_new = date_pkg::bcd_div4(year_step);
`else
    assign leap_cur = 1'b0;
    assign leap_new = 1'b0;
`endif

    assign day_max_cur = date_pkg::month_days(fecha_out2, leap_cur);
    assign day_max_new = date_pkg::month_days(month_step, leap_new);

    bcd_field_step u_day (
        .value    (fecha_out1),
        .min_val  (8'h01),
        .max_val  (day_max_cur),
        .up       (step_up && on_day),
        .down     (step_down && on_day),
        .next_val (day_step)
    );

    bcd_field_step u_month (
        .value    (fecha_out2),
        .min_val  (8'h01),
        .max_val  (8'h12),
        .up       (step_up && on_month),
        .down     (step_down && on_month),
        .next_val (month_step)
    );

    bcd_field_step u_year (
        .value    (fecha_out3),
        .min_val  (8'h00),
        .max_val  (8'h99),
        .up       (step_up && on_year),
        .down     (step_down && on_year),
        .next_val (year_step)
    );

    // A month/year step can shorten the month under the current day
    always_comb begin
        day_fixed = day_step;
        if ((step_up || step_down) && (on_month || on_year) && (day_step > day_max_new)) begin
            day_fixed = day_max_new;
        end
    end

    always_comb begin
        cursor_moved = direccion_actual_pantalla;
        if (move_right) begin
            if (on_day)        cursor_moved = DIR_MONTH;
            else if (on_month) cursor_moved = DIR_YEAR;
            else               cursor_moved = DIR_DAY;
        end else if (move_left) begin
            if (on_day)        cursor_moved = DIR_YEAR;
            else if (on_year)  cursor_moved = DIR_MONTH;
            else               cursor_moved = DIR_DAY;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        day_next   = fecha_out1;
        month_next = fecha_out2;
        year_next  = fecha_out3;
        dir_next   = direccion_actual_pantalla;
        req_next   = write_req;
        err_next   = 1'b0;
        case (state)
            date_pkg::IDLE: begin
                if (rtc_valid) begin
                    day_next   = rtc_day;
                    month_next = rtc_month;
                    year_next  = rtc_year;
                end
                if (programar_on) begin
                    state_next = date_pkg::EDIT;
                    dir_next   = DIR_DAY;
                end
            end
            date_pkg::EDIT: begin
                if (programar_on) begin
                    day_next   = day_fixed;
                    month_next = month_step;
                    year_next  = year_step;
                    dir_next   = cursor_moved;
                end else begin
                    state_next = date_pkg::COMMIT;
                    dir_next   = date_pkg::DIR_NONE;
                    req_next   = 1'b1;
                    cnt_next   = 8'd0;
                end
            end
            date_pkg::COMMIT: begin
                if (write_ack) begin
                    state_next = date_pkg::IDLE;
                    req_next   = 1'b0;
                    cnt_next   = 8'd0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = date_pkg::IDLE;
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next   = cnt + 8'd1;
                end
            end
            default: begin
                state_next = date_pkg::IDLE;
                dir_next   = date_pkg::DIR_NONE;
                req_next   = 1'b0;
                cnt_next   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                     <= date_pkg::IDLE;
            cnt                       <= 8'd0;
            fecha_out1                <= 8'h01;
            fecha_out2                <= 8'h01;
            fecha_out3                <= 8'h00;
            direccion_actual_pantalla <= date_pkg::DIR_NONE;
            write_req                 <= 1'b0;
            write_err                 <= 1'b0;
        end else begin
            state                     <= state_next;
            cnt                       <= cnt_next;
            fecha_out1                <= day_next;
            fecha_out2                <= month_next;
            fecha_out3                <= year_next;
            direccion_actual_pantalla <= dir_next;
            write_req                 <= req_next;
            write_err                 <= err_next;
        end
    end

endmodule

// File: tb/tb_date_edit_ctrl.sv
// tb/tb_date_edit_ctrl.sv - directed table-driven bench for date_edit_ctrl
module tb_date_edit_ctrl;

    localparam int TIMEOUT = 255;

`ifdef DATE_EDIT_LEAP_EN
    localparam logic [7:0] FEB00    = 8'h29;
    localparam logic [7:0] FEB00_M1 = 8'h28;
    localparam logic [7:0] FEB24    = 8'h29;
`else
    localparam logic [7:0] FEB00    = 8'h28;
    localparam logic [7:0] FEB00_M1 = 8'h27;
    localparam logic [7:0] FEB24    = 8'h28;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       programar_on, btn_up, btn_down, btn_left, btn_right, rtc_valid, write_ack;
    logic [7:0] rtc_day, rtc_month, rtc_year;
    logic [7:0] fecha_out1, fecha_out2, fecha_out3;
    logic [3:0] direccion_actual_pantalla;
    logic       write_req, write_err;

    int checks = 0;
    int errors = 0;

    date_edit_ctrl dut (
        .clk                       (clk),
        .reset                     (reset),
        .programar_on              (programar_on),
        .btn_up                    (btn_up),
        .btn_down                  (btn_down),
        .btn_left                  (btn_left),
        .btn_right                 (btn_right),
        .rtc_valid                 (rtc_valid),
        .rtc_day                   (rtc_day),
        .rtc_month                 (rtc_month),
        .rtc_year                  (rtc_year),
        .write_ack                 (write_ack),
        .fecha_out1                (fecha_out1),
        .fecha_out2                (fecha_out2),
        .fecha_out3                (fecha_out3),
        .direccion_actual_pantalla (direccion_actual_pantalla),
        .write_req                 (write_req),
        .write_err                 (write_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       up, down, left, right, rtc;
        logic [7:0] d, m, y;
        logic [3:0] dir;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_date(input string name, input logic [7:0] d, input logic [7:0] m,
                              input logic [7:0] y, input logic [3:0] dir);
        checks++;
        if ({fecha_out1, fecha_out2, fecha_out3, direccion_actual_pantalla} !== {d, m, y, dir}) begin
            errors++;
            $display("FAIL %s: got %h/%h/%h dir %0d, expected %h/%h/%h dir %0d", name,
                     fecha_out1, fecha_out2, fecha_out3, direccion_actual_pantalla, d, m, y, dir);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic rtc_load(input logic [7:0] d, input logic [7:0] m, input logic [7:0] y);
        rtc_day = d; rtc_month = m; rtc_year = y; rtc_valid = 1'b1;
        tick();
        rtc_valid = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h99, 4'd3};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 8'h01, 8'h99, 4'd3};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 8'h01, 8'h99, 4'd3};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 8'h01, 8'h99, 4'd3};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 8'h01, 8'h99, 4'd4};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 8'h01, 8'h99, 4'd5};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31, 8'h01, 8'h00, 4'd5};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 8'h01, 8'h00, 4'd3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h31, 8'h01, 8'h00, 4'd5};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h31, 8'h01, 8'h00, 4'd4};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 8'h01, 8'h00, 4'd4};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 8'h12, 8'h00, 4'd4};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31, 8'h01, 8'h00, 4'd4};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FEB00, 8'h02, 8'h00, 4'd4};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, FEB00, 8'h03, 8'h00, 4'd5};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FEB00, 8'h03, 8'h99, 4'd5};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, FEB00, 8'h03, 8'h98, 4'd4};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FEB00, 8'h03, 8'h98, 4'd3};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, FEB00_M1, 8'h03, 8'h98, 4'd3};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FEB00_M1, 8'h03, 8'h98, 4'd3};

        reset = 1'b1; programar_on = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; rtc_valid = 1'b0; write_ack = 1'b0;
        rtc_day = 8'h15; rtc_month = 8'h06; rtc_year = 8'h10;
        tick();
        tick();
        check_date("reset_date", 8'h01, 8'h01, 8'h00, 4'd0);
        check_bit("reset_req", write_req, 1'b0);
        check_bit("reset_err", write_err, 1'b0);
        reset = 1'b0;
        tick();

        rtc_load(8'h28, 8'h02, 8'h24);
        check_date("idle_rtc_load", 8'h28, 8'h02, 8'h24, 4'd0);
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        check_date("idle_btn_ignored", 8'h28, 8'h02, 8'h24, 4'd0);

        rtc_load(8'h31, 8'h01, 8'h99);
        programar_on = 1'b1;
        tick();
        check_date("enter_edit", 8'h31, 8'h01, 8'h99, 4'd3);

        rtc_day = 8'h15; rtc_month = 8'h06; rtc_year = 8'h10;
        for (int i = 0; i < 20; i++) begin
            btn_up = vecs[i].up; btn_down = vecs[i].down;
            btn_left = vecs[i].left; btn_right = vecs[i].right; rtc_valid = vecs[i].rtc;
            tick();
            btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0; rtc_valid = 1'b0;
            check_date($sformatf("vec%0d", i), vecs[i].d, vecs[i].m, vecs[i].y, vecs[i].dir);
        end

        programar_on = 1'b0;
        tick();
        check_bit("commit_req", write_req, 1'b1);
        check_date("commit_dir", FEB00_M1, 8'h03, 8'h98, 4'd0);
        btn_up = 1'b1;
        tick();
        btn_up = 1'b0;
        check_date("commit_btn_ignored", FEB00_M1, 8'h03, 8'h98, 4'd0);
        n = 0;
        for (int i = 3; i < 10; i++) begin
            tick();
            if (write_req) n++;
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL commit_hold: write_req high %0d of 7 cycles", n);
        end
        write_ack = 1'b1;
        tick();
        write_ack = 1'b0;
        check_bit("ack_req_drop", write_req, 1'b0);
        check_bit("ack_no_err", write_err, 1'b0);
        rtc_load(8'h31, 8'h03, 8'h24);
        check_date("idle_after_ack", 8'h31, 8'h03, 8'h24, 4'd0);

        programar_on = 1'b1;
        tick();
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        btn_down = 1'b1;
        tick();
        btn_down = 1'b0;
        check_date("feb_clamp_month", FEB24, 8'h02, 8'h24, 4'd4);
        btn_right = 1'b1;
        tick();
        btn_right = 1'b0;
        btn_down = 1'b1;
        tick();
        btn_down = 1'b0;
        check_date("feb_clamp_year", 8'h28, 8'h02, 8'h23, 4'd5);

        programar_on = 1'b0;
        tick();
        n = 0;
        while (write_req && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len: write_req held %0d cycles, expected %0d", n, TIMEOUT);
        end
        check_bit("timeout_err_pulse", write_err, 1'b1);
        tick();
        check_bit("timeout_err_clear", write_err, 1'b0);
        rtc_load(8'h12, 8'h11, 8'h05);
        check_date("idle_after_timeout", 8'h12, 8'h11, 8'h05, 4'd0);

        programar_on = 1'b1;
        tick();
        programar_on = 1'b0;
        tick();
        check_bit("pre_reset_req", write_req, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_date("async_reset_date", 8'h01, 8'h01, 8'h00, 4'd0);
        check_bit("async_reset_req", write_req, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_bit("post_reset_idle", write_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
